clk_rst_sequencer: RTL and testbench
====================================

Name: clk_rst_sequencer

Overview:
- Sequences bring-up of the two MMCMs and release of the per-domain resets (tx local, tx out, 250MHz, rx local).
- Runs on the free-running 100MHz board clock.
- Drives the MMCM reset and the domain-reset request lines, which feed each domain's 3-FF reset synchronizers.
- Monitors both MMCM lock outputs, retries on lock timeout, re-sequences on lock loss, and latches a fault after repeated failure.

Parameters:
- RST_CYCLES, 16: cycles mmcmRstOut is held high per attempt.
- LOCK_TIMEOUT, 100000: cycles allowed for both locks after MMCM reset release (1ms).
- SETTLE_CYCLES, 1024: cycles both locks must stay continuously high before any domain release.
- STAGE_GAP, 64: cycles between successive domain releases.
- MAX_RETRIES, 4: failed attempts before entering FAULT.
- SYNC_DEPTH, 3: synchronizer depth for lock inputs.

Ports:
- clkIn, in, 1: 100MHz board clock (post-BUFG).
- rstNIn, in, 1: reset, asynchronous, active-low.
- mmcm0LockedIn, in, 1: tx/250 MMCM lock; asynchronous.
- mmcm1LockedIn, in, 1: rx MMCM lock; asynchronous.
- swRetryIn, in, 1: single-cycle pulse; leaves FAULT.
- mmcmRstOut, out, 1: reset to both MMCMs, active-high.
- rstTxReqOut, out, 1: tx local + tx out domain reset request, active-high.
- rstRxReqOut, out, 1: rx local domain reset request, active-high.
- rst250ReqOut, out, 1: 250MHz domain reset request, active-high.
- readyOut, out, 1: all domains released, locks healthy.
- faultOut, out, 1: retry limit exhausted.
- retryCntOut, out, 3: failed attempts in current bring-up.
- lockLossCntOut, out, 8: lock-loss events while in RUN; saturates at 255.

Behaviour:

Reset (rstNIn low):
- State is MMCM_RST.
- mmcmRstOut=1; all rst*ReqOut=1.
- readyOut=0, faultOut=0, both counters=0, lock synchronizers=0.

Lock synchronizers:
- Each lock input passes through a SYNC_DEPTH-FF synchronizer.
- lockOk = AND of both synchronized locks.
- All decisions use lockOk only.

States:
- MMCM_RST:
  - mmcmRstOut=1; timer counts RST_CYCLES.
  - Then go to WAIT_LOCK with timer cleared; mmcmRstOut drops on that transition.
- WAIT_LOCK:
  - If lockOk, go to SETTLE.
  - If the timer reaches LOCK_TIMEOUT-1 without lockOk, it is a failed attempt.
- SETTLE:
  - lockOk high for SETTLE_CYCLES consecutive cycles, then go to REL_TX.
  - lockOk low at any point is a failed attempt.
- REL_TX: rstTxReqOut deasserts on entry; after STAGE_GAP cycles go to REL_RX.
- REL_RX: rstRxReqOut deasserts on entry; after STAGE_GAP cycles go to REL_250.
- REL_250: rst250ReqOut deasserts on entry; after STAGE_GAP cycles go to RUN.
- RUN:
  - readyOut=1 and retryCnt cleared.
  - lockOk low: in the same edge, assert all three reset requests, clear readyOut, increment lockLossCnt (saturating), go to MMCM_RST.
  - A lock-loss restart does not count as a retry.
- FAULT:
  - mmcmRstOut=1; all reset requests=1; faultOut=1.
  - Stays here until swRetryIn; then clear retryCnt and faultOut and go to MMCM_RST.
  - swRetryIn is ignored in every other state.

Failed attempt (WAIT_LOCK timeout, lockOk drop in SETTLE, or lockOk drop in any REL_* state):
- All reset requests re-assert in the same edge.
- retryCnt increments.
- If the new retryCnt == MAX_RETRIES, go to FAULT; otherwise go to MMCM_RST.

Invariants:
- Reset requests deassert only in the order tx, rx, 250.
- Once any earlier stage is re-asserted, every later stage is re-asserted too.
- All outputs are registered; no output is combinational from an input.

Timer:
- One shared down-counter, 17 bits, sized for max(LOCK_TIMEOUT, SETTLE_CYCLES).
- Reloaded on every state transition.

Async reset mid-sequence: immediate return to the reset values above, regardless of state.

Decomposition:
- Package clk_rst_pkg:
  - seqState_t enum: MMCM_RST, WAIT_LOCK, SETTLE, REL_TX, REL_RX, REL_250, RUN, FAULT.
  - Default timing constants.
  - Counter width constants.
- Lock synchronizers reuse the existing synchronizer_ff (rstIn tied to 1'b0, DEPTH=SYNC_DEPTH).
- No new sub-module; FSM and timer live in one module.

Test Plan:
Use RST_CYCLES=4, LOCK_TIMEOUT=50, SETTLE_CYCLES=8, STAGE_GAP=4, MAX_RETRIES=2, SYNC_DEPTH=3 unless stated.
- Normal bring-up:
  - Stimulus: raise both locks 10 cycles after mmcmRstOut falls.
  - Expect: mmcmRstOut high 4 cycles; rstTxReqOut falls 3+8 cycles after the locks rise; rstRxReqOut 4 cycles later, then rst250ReqOut 4 cycles later; readyOut 4 cycles after that.
- Lock timeout:
  - Stimulus: hold mmcm1LockedIn low throughout.
  - Expect: retryCntOut=1 after 50 cycles in WAIT_LOCK and mmcmRstOut pulses again; after the second timeout faultOut=1 with all resets high. A swRetryIn pulse then gives faultOut=0, retryCntOut=0 and mmcmRstOut=1.
- Settle glitch:
  - Stimulus: drop mmcm0LockedIn for 1 cycle mid-SETTLE.
  - Expect: retryCntOut=1, re-sequence from MMCM_RST, no reset request ever deasserted.
- RUN lock loss:
  - Stimulus: in RUN, drop mmcm1LockedIn.
  - Expect: 3 sync cycles later, all three requests high in the same cycle, readyOut=0, lockLossCntOut=1, retryCntOut=0; full re-release once locks return. After 256 such events the counter holds at 255.
- Async reset mid-REL_RX:
  - Stimulus: pulse rstNIn low for a fraction of a cycle.
  - Expect: all outputs at reset values immediately, without waiting for a clock edge; sequence restarts from MMCM_RST.
- swRetryIn outside FAULT:
  - Stimulus: pulse swRetryIn in WAIT_LOCK and in RUN.
  - Expect: no state change, counters unchanged.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the board-clock reset sequencer.
// Decodes each sequencer state to the levels of its output pins.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    MMCM_RST,
    WAIT_LOCK,
    SETTLE,
    REL_TX,
    REL_RX,
    REL_250,
    RUN,
    FAULT
  } seqState_t;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 100000;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;
  localparam int unsigned DEF_STAGE_GAP     = 64;
  localparam int unsigned DEF_MAX_RETRIES   = 4;
  localparam int unsigned DEF_SYNC_DEPTH    = 3;

  localparam int TIMER_W = 17;
  localparam int RETRY_W = 3;
  localparam int LOSS_W  = 8;

  typedef struct packed {
    logic mmcmRst;
    logic rstTx;
    logic rstRx;
    logic rst250;
    logic ready;
    logic fault;
  } seqOut_t;

  // A later stage is only released in states where every earlier stage is too,
  // so the release order holds by construction.
  function automatic seqOut_t decodeState(input seqState_t s);
    seqOut_t o;
    o.mmcmRst = (s == MMCM_RST) || (s == FAULT);
    o.rstTx   = !(s inside {REL_TX, REL_RX, REL_250, RUN});
    o.rstRx   = !(s inside {REL_RX, REL_250, RUN});
    o.rst250  = !(s inside {REL_250, RUN});
    o.ready   = (s == RUN);
    o.fault   = (s == FAULT);
    return o;
  endfunction

endpackage

// File: rtl/synchronizer_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
// rstNIn clears the chain asynchronously; rstIn clears it synchronously.
module synchronizer_ff #(
  parameter int DEPTH = 3
) (
  input  logic clkIn,
  input  logic rstNIn,
  input  logic rstIn,
  input  logic dIn,
  output logic qOut
);

  logic [DEPTH-1:0] syncQ;

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      syncQ <= '0;
    end else if (rstIn) begin
      syncQ <= '0;
    end else begin
      syncQ <= {syncQ[DEPTH-2:0], dIn};
    end
  end

  assign qOut = syncQ[DEPTH-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// MMCM bring-up and ordered domain-reset release on the 100MHz board clock,
// with lock-timeout retry, lock-loss re-sequencing and a latched fault.
module clk_rst_sequencer
  import clk_rst_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int          SYNC_DEPTH    = DEF_SYNC_DEPTH
) (
  input  logic        clkIn,
  input  logic        rstNIn,
  input  logic        mmcm0LockedIn,
  input  logic        mmcm1LockedIn,
  input  logic        swRetryIn,
  output logic        mmcmRstOut,
  output logic        rstTxReqOut,
  output logic        rstRxReqOut,
  output logic        rst250ReqOut,
  output logic        readyOut,
  output logic        faultOut,
  output logic [2:0]  retryCntOut,
  output logic [7:0]  lockLossCntOut
);

  // state     | meaning
  // MMCM_RST  | MMCM reset held for RST_CYCLES, all domains in reset
  // WAIT_LOCK | MMCM reset released, waiting up to LOCK_TIMEOUT for both locks
  // SETTLE    | both locks seen, must hold for SETTLE_CYCLES
  // REL_TX    | tx local/out domains released, STAGE_GAP wait
  // REL_RX    | rx local domain released, STAGE_GAP wait
  // REL_250   | 250MHz domain released, STAGE_GAP wait
  // RUN       | everything released, watching for lock loss
  // FAULT     | retry limit hit, held until swRetryIn

  logic mmcm0Sync;
  logic mmcm1Sync;
  logic lockOk;

  seqState_t state;
  seqState_t stateNext;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timerNext;
  logic [RETRY_W-1:0] retryCnt;
  logic [RETRY_W-1:0] retryNext;
  logic [LOSS_W-1:0]  lossCnt;
  logic [LOSS_W-1:0]  lossNext;
  logic               timerDone;
  logic               failAttempt;
  seqOut_t            outQ;
  seqOut_t            outNext;

  synchronizer_ff #(.DEPTH(SYNC_DEPTH)) uSyncLock0 (
    .clkIn (clkIn),
    .rstNIn(rstNIn),
    .rstIn (1'b0),
    .dIn   (mmcm0LockedIn),
    .qOut  (mmcm0Sync)
  );

  synchronizer_ff #(.DEPTH(SYNC_DEPTH)) uSyncLock1 (
    .clkIn (clkIn),
    .rstNIn(rstNIn),
    .rstIn (1'b0),
    .dIn   (mmcm1LockedIn),
    .qOut  (mmcm1Sync)
  );

  assign lockOk = mmcm0Sync & mmcm1Sync;

  // Terminal count is zero, so a state lasts (load + 1) cycles.
  function automatic logic [TIMER_W-1:0] timerLoad(input seqState_t s);
    logic [TIMER_W-1:0] v;
    case (s)
      MMCM_RST:                v = TIMER_W'(RST_CYCLES - 1);
      WAIT_LOCK:               v = TIMER_W'(LOCK_TIMEOUT - 1);
      SETTLE:                  v = TIMER_W'(SETTLE_CYCLES - 1);
      REL_TX, REL_RX, REL_250: v = TIMER_W'(STAGE_GAP - 1);
      default:                 v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    stateNext   = state;
    retryNext   = retryCnt;
    lossNext    = lossCnt;
    failAttempt = 1'b0;
    timerDone   = (timer == '0);
    timerNext   = timerDone ? timer : timer - 1'b1;

    case (state)
      MMCM_RST: begin
        if (timerDone) stateNext = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lockOk)         stateNext = SETTLE;
        else if (timerDone) failAttempt = 1'b1;
      end
      SETTLE: begin
        if (!lockOk)        failAttempt = 1'b1;
        else if (timerDone) stateNext = REL_TX;
      end
      REL_TX: begin
        if (!lockOk)        failAttempt = 1'b1;
        else if (timerDone) stateNext = REL_RX;
      end
      REL_RX: begin
        if (!lockOk)        failAttempt = 1'b1;
        else if (timerDone) stateNext = REL_250;
      end
      REL_250: begin
        if (!lockOk)        failAttempt = 1'b1;
        else if (timerDone) stateNext = RUN;
      end
      RUN: begin
        // Lock loss after a good bring-up restarts without spending a retry.
        if (!lockOk) begin
          stateNext = MMCM_RST;
          if (lossCnt != '1) lossNext = lossCnt + 1'b1;
        end
      end
      FAULT: begin
        if (swRetryIn) begin
          stateNext = MMCM_RST;
          retryNext = '0;
        end
      end
      default: stateNext = MMCM_RST;
    endcase

    if (failAttempt) begin
      retryNext = retryCnt + 1'b1;
      stateNext = (retryNext == RETRY_W'(MAX_RETRIES)) ? FAULT : MMCM_RST;
    end

    if (stateNext == RUN) retryNext = '0;

    if (stateNext != state) timerNext = timerLoad(stateNext);

    outNext = decodeState(stateNext);
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state    <= MMCM_RST;
      timer    <= timerLoad(MMCM_RST);
      retryCnt <= '0;
      lossCnt  <= '0;
      outQ     <= decodeState(MMCM_RST);
    end else begin
      state    <= stateNext;
      timer    <= timerNext;
      retryCnt <= retryNext;
      lossCnt  <= lossNext;
      outQ     <= outNext;
    end
  end

  assign mmcmRstOut     = outQ.mmcmRst;
  assign rstTxReqOut    = outQ.rstTx;
  assign rstRxReqOut    = outQ.rstRx;
  assign rst250ReqOut   = outQ.rst250;
  assign readyOut       = outQ.ready;
  assign faultOut       = outQ.fault;
  assign retryCntOut    = retryCnt;
  assign lockLossCntOut = lossCnt;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench: stimulus queues each expected output change with its cycle,
// a monitor pops and compares whenever the registered outputs change.
module tb_clk_rst_sequencer;

  logic       clkIn = 1'b0;
  logic       rstNIn;
  logic       mmcm0LockedIn;
  logic       mmcm1LockedIn;
  logic       swRetryIn;
  logic       mmcmRstOut;
  logic       rstTxReqOut;
  logic       rstRxReqOut;
  logic       rst250ReqOut;
  logic       readyOut;
  logic       faultOut;
  logic [2:0] retryCntOut;
  logic [7:0] lockLossCntOut;

  typedef struct {
    int          cyc;
    logic [16:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   cyc  = 0;
  int   nCmp = 0;
  int   nBad = 0;

  logic       mRst, mTx, mRx, m250, mRdy, mFlt;
  logic [2:0] mRetry;
  logic [7:0] mLoss;

  clk_rst_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (50),
    .SETTLE_CYCLES(8),
    .STAGE_GAP    (4),
    .MAX_RETRIES  (2),
    .SYNC_DEPTH   (3)
  ) dut (
    .clkIn         (clkIn),
    .rstNIn        (rstNIn),
    .mmcm0LockedIn (mmcm0LockedIn),
    .mmcm1LockedIn (mmcm1LockedIn),
    .swRetryIn     (swRetryIn),
    .mmcmRstOut    (mmcmRstOut),
    .rstTxReqOut   (rstTxReqOut),
    .rstRxReqOut   (rstRxReqOut),
    .rst250ReqOut  (rst250ReqOut),
    .readyOut      (readyOut),
    .faultOut      (faultOut),
    .retryCntOut   (retryCntOut),
    .lockLossCntOut(lockLossCntOut)
  );

  always #5 clkIn = ~clkIn;
  always @(posedge clkIn) cyc++;

  function automatic logic [16:0] dutVec();
    return {mmcmRstOut, rstTxReqOut, rstRxReqOut, rst250ReqOut,
            readyOut, faultOut, retryCntOut, lockLossCntOut};
  endfunction

  task automatic expectAt(input int c);
    exp_t e;
    e.cyc = c;
    e.val = {mRst, mTx, mRx, m250, mRdy, mFlt, mRetry, mLoss};
    sbQ.push_back(e);
  endtask

  task automatic toNeg(input int c);
    do @(negedge clkIn); while (cyc < c);
  endtask

  // Drop mmcm1 in RUN at negedge n, restore it at n+5, wait for RUN again.
  task automatic lockLoss(input int n, input int lossVal);
    toNeg(n);
    mmcm1LockedIn = 1'b0;
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; mLoss = 8'(lossVal);
    expectAt(n + 4);
    mRst = 0; expectAt(n + 8);
    mTx  = 0; expectAt(n + 17);
    mRx  = 0; expectAt(n + 21);
    m250 = 0; expectAt(n + 25);
    mRdy = 1; expectAt(n + 29);
    toNeg(n + 5);
    mmcm1LockedIn = 1'b1;
    toNeg(n + 30);
  endtask

  initial begin : monitor
    logic [16:0] prev;
    logic [16:0] cur;
    exp_t        e;
    prev = '1;
    @(posedge clkIn);
    forever begin
      @(negedge clkIn or negedge rstNIn);
      #1;
      cur = dutVec();
      if (cur !== prev) begin
        nCmp++;
        if (sbQ.size() == 0) begin
          nBad++;
          $display("FAIL sb_unexpected cyc=%0d got=%h required=no_change", cyc, cur);
        end else begin
          e = sbQ.pop_front();
          if (e.cyc != cyc || e.val !== cur) begin
            nBad++;
            $display("FAIL sb_event got cyc=%0d val=%h required cyc=%0d val=%h",
                     cyc, cur, e.cyc, e.val);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin : stimulus
    int n;
    rstNIn = 1'b0; mmcm0LockedIn = 1'b0; mmcm1LockedIn = 1'b0; swRetryIn = 1'b0;
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; mFlt = 0; mRetry = 0; mLoss = 0;
    expectAt(1);

    // Normal bring-up
    toNeg(3);
    rstNIn = 1'b1;
    mRst = 0; expectAt(7);
    toNeg(17);
    mmcm0LockedIn = 1'b1; mmcm1LockedIn = 1'b1;
    mTx = 0; expectAt(29);
    mRx = 0; expectAt(33);
    m250 = 0; expectAt(37);
    mRdy = 1; expectAt(41);

    // swRetryIn in RUN is ignored
    toNeg(45); swRetryIn = 1'b1;
    toNeg(46); swRetryIn = 1'b0;

    // RUN lock loss
    lockLoss(50, 1);

    // Lock loss, then async reset mid-REL_RX of the re-release
    toNeg(82);
    mmcm1LockedIn = 1'b0;
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; mLoss = 2; expectAt(86);
    mRst = 0; expectAt(90);
    mTx = 0; expectAt(99);
    mRx = 0; expectAt(103);
    toNeg(87); mmcm1LockedIn = 1'b1;
    toNeg(103);
    @(posedge clkIn);
    #2;
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; mFlt = 0; mRetry = 0; mLoss = 0;
    expectAt(104);
    rstNIn = 1'b0;
    #2;
    rstNIn = 1'b1;
    mRst = 0; expectAt(108);
    mTx = 0; expectAt(117);
    mRx = 0; expectAt(121);
    m250 = 0; expectAt(125);
    mRdy = 1; expectAt(129);

    // Fresh reset, then a one-cycle mmcm0 glitch mid-SETTLE
    toNeg(135);
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; expectAt(135);
    rstNIn = 1'b0;
    mRst = 0; expectAt(141);
    mRst = 1; mRetry = 1; expectAt(148);
    mRst = 0; expectAt(152);
    mTx = 0; expectAt(161);
    mRx = 0; expectAt(165);
    m250 = 0; expectAt(169);
    mRdy = 1; mRetry = 0; expectAt(173);
    toNeg(137); rstNIn = 1'b1;
    toNeg(144); mmcm0LockedIn = 1'b0;
    toNeg(145); mmcm0LockedIn = 1'b1;

    // Lock loss with mmcm1 held low: two timeouts into FAULT, swRetryIn ignored in WAIT_LOCK
    toNeg(180);
    mmcm1LockedIn = 1'b0;
    mRst = 1; mTx = 1; mRx = 1; m250 = 1; mRdy = 0; mLoss = 1; expectAt(184);
    mRst = 0; expectAt(188);
    mRst = 1; mRetry = 1; expectAt(238);
    mRst = 0; expectAt(242);
    mRst = 1; mFlt = 1; mRetry = 2; expectAt(292);
    mFlt = 0; mRetry = 0; expectAt(301);
    mRst = 0; expectAt(305);
    mTx = 0; expectAt(318);
    mRx = 0; expectAt(322);
    m250 = 0; expectAt(326);
    mRdy = 1; expectAt(330);
    toNeg(200); swRetryIn = 1'b1;
    toNeg(201); swRetryIn = 1'b0;
    toNeg(250); swRetryIn = 1'b1;
    toNeg(251); swRetryIn = 1'b0;
    toNeg(300); swRetryIn = 1'b1;
    toNeg(301); swRetryIn = 1'b0;
    toNeg(306); mmcm1LockedIn = 1'b1;

    // Lock-loss counter saturation
    n = 335;
    for (int k = 2; k <= 257; k++) begin
      lockLoss(n, (k > 255) ? 255 : k);
      n += 32;
    end

    toNeg(n + 5);
    nCmp++;
    if (sbQ.size() != 0) begin
      nBad++;
      $display("FAIL sb_drain pending=%0d required=0 next_cyc=%0d", sbQ.size(), sbQ[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
